mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one physical memory port between the CPU datapath's instruction-fetch port (port 1, read-only) and data port (port 2, read/write). Sits between the pipelined LC-3b datapath and physical memory. Serializes requests with a registered request/response handshake. Port 2 has priority, with a starvation guard so port 1 always makes progress.

## Interface
Parameters:
- MAX_D_STREAK, default 4: maximum consecutive port-2 grants while port 1 is pending. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- mem_addr1  in  16  port-1 address (lc3b_word)
- mem_read1  in  1  port-1 read request; held high until mem_resp1 is seen
- mem_rdata1  out  16  port-1 read data; valid while mem_resp1=1
- mem_resp1  out  1  port-1 completion pulse
- mem_addr2  in  16  port-2 address
- mem_read2  in  1  port-2 read request; held until mem_resp2
- mem_write2  in  1  port-2 write request; held until mem_resp2
- mem_wdata2  in  16  port-2 write data
- mem_wmask2  in  2  port-2 byte enables (bit1 = high byte)
- mem_rdata2  out  16  port-2 read data; valid while mem_resp2=1
- mem_resp2  out  1  port-2 completion pulse
- pmem_address  out  16  physical address
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_wdata  out  16  physical write data
- pmem_wmask  out  2  physical byte enables
- pmem_rdata  in  16  physical read data; valid with pmem_resp
- pmem_resp  in  1  physical completion, one cycle

## Operation
- States: IDLE, SERVE1, SERVE2, DONE1, DONE2.
- req1 = mem_read1. req2 = mem_read2 | mem_write2.
- IDLE arbitration, at the clock edge:
  - req2 & !(req1 & streak==MAX_D_STREAK) -> SERVE2.
  - Otherwise, if req1 -> SERVE1.
  - Otherwise stay in IDLE.
- On grant, the arbiter latches address, wdata, wmask and op into registers. pmem_* outputs are driven only from these registers and the state. Request inputs are ignored outside IDLE.
- Port-2 op: mem_write2 takes precedence if both mem_read2 and mem_write2 are high. A read uses pmem_wmask = 2'b11 and pmem_wdata = 0.
- SERVE1 and SERVE2 hold pmem_read or pmem_write high until pmem_resp=1. At that edge:
  - pmem_rdata is captured into the rdata register.
  - The state moves to DONE1 or DONE2.
- DONE1 and DONE2 last exactly one cycle:
  - The matching mem_resp is 1.
  - The matching mem_rdata holds the captured data (the write response also returns captured pmem_rdata).
  - The next state is always IDLE.
- The non-selected mem_rdata holds its last captured value. The requester drops its request at the edge ending DONE.
- streak counter, width 4:
  - Increments (saturating at MAX_D_STREAK) on a port-2 grant while req1=1.
  - Clears to 0 on a port-2 grant with req1=0.
  - Clears to 0 on any port-1 grant.
- pmem_resp in IDLE, DONE1 or DONE2 is ignored and causes no state change.
- Reset values (asynchronous): state=IDLE, streak=0, all registers=0. Outputs: pmem_read=pmem_write=0, pmem_address=pmem_wdata=0, pmem_wmask=0, mem_resp1=mem_resp2=0, mem_rdata1=mem_rdata2=0.
- Reset mid-transaction aborts immediately. No mem_resp is generated for the aborted request. A pmem_resp arriving after reset deasserts is ignored.

## Timing
- Request high in cycle 0 with the arbiter in IDLE:
  - Grant at edge 1; pmem strobe high from cycle 1.
  - If pmem_resp occurs in cycle k (k≥1), mem_resp is high in cycle k+1 and the state is IDLE in cycle k+2.
- Minimum request-to-response latency: 2 cycles (pmem_resp in cycle 1, mem_resp in cycle 2).
- Back-to-back requests: at least one IDLE cycle separates transactions. Next grant is at the earliest edge k+3.
- pmem_address, pmem_wdata and pmem_wmask are stable for the whole SERVE state. The strobe drops in the cycle after pmem_resp.
- Port-1 requests and mem_addr1 must not change while pending. Violations are undefined, but latched values are used.

## Test plan
- Port-1 only: mem_read1=1, addr 0x1234; memory responds 3 cycles later with 0xBEEF -> pmem_read=1 with pmem_address=0x1234 for 3 cycles; mem_resp1=1 with mem_rdata1=0xBEEF for exactly 1 cycle.
- Port-2 write: addr 0x0040, wdata 0xA5A5, wmask 2'b01 -> pmem_write=1 with those latched values; mem_resp2 pulses once; pmem_read stays 0.
- Simultaneous requests: mem_read1 and mem_read2 raised in the same cycle -> port 2 served first; port 1 granted at the edge after DONE2+IDLE; each port gets exactly one response.
- Starvation guard: req1 and req2 held continuously (port 2 reissuing) with MAX_D_STREAK=4 -> grant order is 2,2,2,2,1,2,2,2,2,1; streak resets after each port-1 grant.
- Reset mid-SERVE2: reset asserted asynchronously -> pmem_write falls the same cycle, state is IDLE; a late pmem_resp produces no mem_resp2.
- Spurious pmem_resp in IDLE or DONE1 -> no state change and no extra response pulse; read with both mem_read2 and mem_write2 high -> a write is issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the instruction-fetch
// port (port 1, read-only) and the data port (port 2, read/write). Port 2 wins
// arbitration unless it has already taken MAX_D_STREAK grants in a row while
// port 1 was waiting.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr1,
  input  logic        mem_read1,
  output logic [15:0] mem_rdata1,
  output logic        mem_resp1,
  input  logic [15:0] mem_addr2,
  input  logic        mem_read2,
  input  logic        mem_write2,
  input  logic [15:0] mem_wdata2,
  input  logic [1:0]  mem_wmask2,
  output logic [15:0] mem_rdata2,
  output logic        mem_resp2,
  output logic [15:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SERVE1 = 3'd1;
  localparam logic [2:0] S_SERVE2 = 3'd2;
  localparam logic [2:0] S_DONE1  = 3'd3;
  localparam logic [2:0] S_DONE2  = 3'd4;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  logic [2:0]  r_state;
  logic [3:0]  r_streak;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_wmask;
  logic        r_is_write;
  logic [15:0] r_rdata1;
  logic [15:0] r_rdata2;

  logic w_req1;
  logic w_req2;
  logic w_idle;
  logic w_grant1;
  logic w_grant2;

  assign w_req1 = mem_read1;
  assign w_req2 = mem_read2 | mem_write2;
  assign w_idle = (r_state == S_IDLE);

  // Port 2 is preferred; it yields only when port 1 is waiting and the streak is used up.
  assign w_grant2 = w_idle && w_req2 && !(w_req1 && (r_streak == MAX_STREAK));
  assign w_grant1 = w_idle && !w_grant2 && w_req1;

  // State sequencing plus latching of the granted request's address, data, mask and op.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_is_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant2) begin
            r_state    <= S_SERVE2;
            r_addr     <= mem_addr2;
            r_is_write <= mem_write2;
            r_wdata    <= mem_write2 ? mem_wdata2 : 16'h0000;
            r_wmask    <= mem_write2 ? mem_wmask2 : 2'b11;
          end else if (w_grant1) begin
            r_state    <= S_SERVE1;
            r_addr     <= mem_addr1;
            r_is_write <= 1'b0;
            r_wdata    <= 16'h0000;
            r_wmask    <= 2'b11;
          end
        end
        S_SERVE1: if (pmem_resp) r_state <= S_DONE1;
        S_SERVE2: if (pmem_resp) r_state <= S_DONE2;
        S_DONE1:  r_state <= S_IDLE;
        S_DONE2:  r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Count consecutive port-2 grants taken while port 1 was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_grant2) begin
      if (!w_req1)                      r_streak <= '0;
      else if (r_streak != MAX_STREAK)  r_streak <= r_streak + 4'd1;
    end else if (w_grant1) begin
      r_streak <= '0;
    end
  end

  // Capture physical read data per port; the other port's copy keeps its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else if (pmem_resp) begin
      if (r_state == S_SERVE1) r_rdata1 <= pmem_rdata;
      if (r_state == S_SERVE2) r_rdata2 <= pmem_rdata;
    end
  end

  assign pmem_read    = (r_state == S_SERVE1) || ((r_state == S_SERVE2) && !r_is_write);
  assign pmem_write   = (r_state == S_SERVE2) && r_is_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign pmem_wmask   = r_wmask;

  assign mem_resp1  = (r_state == S_DONE1);
  assign mem_resp2  = (r_state == S_DONE2);
  assign mem_rdata1 = r_rdata1;
  assign mem_rdata2 = r_rdata2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the main sequence drives requests and plays
// the physical memory; a scoreboard checks each mem_resp pulse against the
// response expected when the request was issued.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr1;
  logic        mem_read1;
  logic [15:0] mem_rdata1;
  logic        mem_resp1;
  logic [15:0] mem_addr2;
  logic        mem_read2;
  logic        mem_write2;
  logic [15:0] mem_wdata2;
  logic [1:0]  mem_wmask2;
  logic [15:0] mem_rdata2;
  logic        mem_resp2;
  logic [15:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  typedef struct {
    int          port;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr1    (mem_addr1),
    .mem_read1    (mem_read1),
    .mem_rdata1   (mem_rdata1),
    .mem_resp1    (mem_resp1),
    .mem_addr2    (mem_addr2),
    .mem_read2    (mem_read2),
    .mem_write2   (mem_write2),
    .mem_wdata2   (mem_wdata2),
    .mem_wmask2   (mem_wmask2),
    .mem_rdata2   (mem_rdata2),
    .mem_resp2    (mem_resp2),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input int port, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits for a strobe, checks the physical request every SERVE cycle, answers
  // after lat cycles with rd. Returns in the DONE cycle.
  task automatic serve(input string tag, input logic [15:0] a, input logic w,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input int lat, input logic [15:0] rd, output int waited);
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_grant_in_time"}, 40'(waited < 20), 40'd1);
    for (int i = 1; i <= lat; i++) begin
      chk({tag, "_pmem_req"}, {pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata},
          {!w, w, wm, a, wd});
      if (i == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
      end
      tick();
    end
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0000;
    chk({tag, "_strobe_drop"}, {pmem_read, pmem_write}, 2'b00);
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (mem_resp1 || mem_resp2)) begin
      chk("sb_pending", 40'(sb.size() != 0), 40'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port", 40'(mem_resp2 ? 2 : 1), 40'(e.port));
        chk("sb_data", mem_resp2 ? mem_rdata2 : mem_rdata1, e.data);
      end
    end
  end

  initial begin
    int waited;
    int order [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    reset      = 1'b1;
    mem_addr1  = '0;
    mem_read1  = 1'b0;
    mem_addr2  = '0;
    mem_read2  = 1'b0;
    mem_write2 = 1'b0;
    mem_wdata2 = '0;
    mem_wmask2 = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    tick();
    tick();
    chk("rst_outputs", {pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
                        mem_resp1, mem_resp2}, '0);
    chk("rst_rdata", {mem_rdata1, mem_rdata2}, '0);
    reset = 1'b0;
    tick();

    // Port-1 read, memory answers in the third SERVE cycle.
    mem_addr1 = 16'h1234;
    mem_read1 = 1'b1;
    expect_resp(1, 16'hBEEF);
    serve("p1_read", 16'h1234, 1'b0, 16'h0000, 2'b11, 3, 16'hBEEF, waited);
    chk("p1_grant_latency", 40'(waited), 40'd1);
    chk("p1_done", {mem_resp1, mem_resp2, mem_rdata1}, {1'b1, 1'b0, 16'hBEEF});
    mem_read1 = 1'b0;
    tick();
    chk("p1_one_pulse", {mem_resp1, pmem_read, pmem_write}, 3'b000);

    // Port-2 write at minimum latency.
    mem_addr2  = 16'h0040;
    mem_wdata2 = 16'hA5A5;
    mem_wmask2 = 2'b01;
    mem_write2 = 1'b1;
    expect_resp(2, 16'h0F0F);
    serve("p2_write", 16'h0040, 1'b1, 16'hA5A5, 2'b01, 1, 16'h0F0F, waited);
    chk("p2_done", {mem_resp2, mem_rdata2}, {1'b1, 16'h0F0F});
    chk("p1_rdata_holds", mem_rdata1, 16'hBEEF);
    mem_write2 = 1'b0;
    tick();
    chk("p2_one_pulse", {mem_resp2, pmem_read, pmem_write}, 3'b000);

    // Simultaneous reads: port 2 first, port 1 after DONE2 + IDLE.
    mem_addr1 = 16'h0100;
    mem_addr2 = 16'h0200;
    mem_read1 = 1'b1;
    mem_read2 = 1'b1;
    expect_resp(2, 16'h2222);
    expect_resp(1, 16'h1111);
    serve("sim_p2", 16'h0200, 1'b0, 16'h0000, 2'b11, 1, 16'h2222, waited);
    mem_read2 = 1'b0;
    serve("sim_p1", 16'h0100, 1'b0, 16'h0000, 2'b11, 2, 16'h1111, waited);
    chk("sim_p1_gap", 40'(waited), 40'd2);
    mem_read1 = 1'b0;
    tick();

    // Starvation guard: both requests held, grant order follows the streak limit.
    mem_addr1 = 16'h1111;
    mem_addr2 = 16'h2222;
    mem_read1 = 1'b1;
    mem_read2 = 1'b1;
    for (int g = 0; g < 10; g++) begin
      logic [15:0] a;
      a = (order[g] == 1) ? 16'h1111 : 16'h2222;
      expect_resp(order[g], ~a);
      serve($sformatf("starve_g%0d", g), a, 1'b0, 16'h0000, 2'b11, 1, ~a, waited);
    end
    mem_read1 = 1'b0;
    mem_read2 = 1'b0;
    tick();

    // Asynchronous reset in the middle of a port-2 write.
    mem_addr2  = 16'h0300;
    mem_wdata2 = 16'h1234;
    mem_wmask2 = 2'b10;
    mem_write2 = 1'b1;
    tick();
    chk("rst_mid_write_active", {pmem_write, pmem_address}, {1'b1, 16'h0300});
    #1 reset = 1'b1;
    mem_write2 = 1'b0;
    #1 chk("rst_mid_strobe_drop", {pmem_read, pmem_write, pmem_address}, '0);
    tick();
    reset = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hDEAD;
    tick();
    pmem_resp = 1'b0;
    chk("rst_late_resp", {mem_resp2, pmem_read, pmem_write}, 3'b000);
    tick();
    chk("rst_no_resp2", {mem_resp2, mem_rdata2}, {1'b0, 16'h0000});

    // Spurious pmem_resp while IDLE.
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hFFFF;
    tick();
    pmem_resp = 1'b0;
    chk("spur_idle", {mem_resp1, mem_resp2, pmem_read, pmem_write, mem_rdata1, mem_rdata2},
        {4'b0000, 16'h0000, 16'h0000});

    // Spurious pmem_resp during DONE1.
    mem_addr1 = 16'h0500;
    mem_read1 = 1'b1;
    expect_resp(1, 16'h7777);
    serve("spur_p1", 16'h0500, 1'b0, 16'h0000, 2'b11, 1, 16'h7777, waited);
    mem_read1  = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hFFFF;
    tick();
    pmem_resp = 1'b0;
    chk("spur_done1", {mem_resp1, pmem_read, pmem_write, mem_rdata1}, {3'b000, 16'h7777});
    tick();
    chk("spur_done1_idle", {mem_resp1, mem_resp2, pmem_read, pmem_write}, 4'b0000);

    // Read and write both asserted on port 2: write wins.
    mem_addr2  = 16'h0600;
    mem_wdata2 = 16'hC3C3;
    mem_wmask2 = 2'b11;
    mem_read2  = 1'b1;
    mem_write2 = 1'b1;
    expect_resp(2, 16'h1357);
    serve("rw_both", 16'h0600, 1'b1, 16'hC3C3, 2'b11, 2, 16'h1357, waited);
    mem_read2  = 1'b0;
    mem_write2 = 1'b0;
    tick();
    tick();
    chk("sb_drained", 40'(sb.size()), 40'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
